// File: rtl/loc_step_unit.sv
// Single-step location datapath: neighbour location, edge flag and a location register.
// Optional LOC_STEP_SAT_EN makes an edge-crossing step hold at curLoc instead of wrapping.

module loc_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] res
);
  // Carry-out is not needed anywhere, so the sum is kept to 4 bits.
  assign res = a + b + {3'b000, ci};
endmodule

module loc_mux2x4 (
  input  logic       sel,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module loc_reg4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] val_q;
  logic [3:0] val_d;

  always_comb begin
    val_d = val_q;
    if (ld) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= 4'h0;
    else     val_q <= val_d;
  end

  assign q = val_q;
endmodule

module loc_step_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgLd,
  input  logic [1:0] dir,
  input  logic [7:0] curLoc,
  output logic [7:0] nxtLoc,
  output logic       cntReach,
  output logic [7:0] locQ
);
  logic       sl;
  logic [3:0] add_to;
  logic [3:0] to_add;
  logic [3:0] res;
  logic [3:0] hi_q;
  logic [3:0] lo_q;
  logic [7:0] step_loc;

  // Directions 01/10 move the high field, 00/11 the low field.
  assign sl     = dir[1] ^ dir[0];
  assign to_add = dir[0] ? 4'b0001 : 4'b1111;

  loc_mux2x4 u_mux (
    .sel (sl),
    .in0 (curLoc[3:0]),
    .in1 (curLoc[7:4]),
    .out (add_to)
  );

  loc_adder4 u_add (
    .a   (add_to),
    .b   (to_add),
    .ci  (1'b0),
    .res (res)
  );

  loc_reg4 u_hi_reg (
    .clk (clk),
    .rst (rst),
    .ld  (rgLd),
    .d   (curLoc[7:4]),
    .q   (hi_q)
  );

  loc_reg4 u_lo_reg (
    .clk (clk),
    .rst (rst),
    .ld  (rgLd),
    .d   (curLoc[3:0]),
    .q   (lo_q)
  );

  // +1 from 15 and -1 from 0 both land on zero after adding dir[0].
  assign cntReach = ((add_to + {3'b000, dir[0]}) == 4'h0);
  assign step_loc = sl ? {res, curLoc[3:0]} : {curLoc[7:4], res};

  always_comb begin
    nxtLoc = step_loc;
`ifdef LOC_STEP_SAT_EN
    if (cntReach) nxtLoc = curLoc;
`else
    nxtLoc = step_loc;
`endif
  end

  assign locQ = {hi_q, lo_q};
endmodule

// File: tb/tb_loc_step_unit.sv
// Scoreboard bench for loc_step_unit: stimulus pushes expectations, a monitor pops and compares.

module tb_loc_step_unit;
  logic       clk;
  logic       rst;
  logic       rgLd;
  logic [1:0] dir;
  logic [7:0] curLoc;
  logic [7:0] nxtLoc;
  logic       cntReach;
  logic [7:0] locQ;

  typedef struct {
    int         tag;
    logic [7:0] exp_nxt;
    logic       exp_reach;
    logic [7:0] exp_locq;
    logic       chk_locq;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  bit   stim_done  = 0;

  loc_step_unit dut (
    .clk      (clk),
    .rst      (rst),
    .rgLd     (rgLd),
    .dir      (dir),
    .curLoc   (curLoc),
    .nxtLoc   (nxtLoc),
    .cntReach (cntReach),
    .locQ     (locQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector per cycle: drive just after the rising edge, expectation queued for the monitor.
  task automatic applyStimulus(input int tag, input logic r, input logic ld,
                               input logic [1:0] d, input logic [7:0] cur,
                               input logic [7:0] e_nxt, input logic e_reach,
                               input logic [7:0] e_locq, input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    rgLd   = ld;
    dir    = d;
    curLoc = cur;
    e.tag       = tag;
    e.exp_nxt   = e_nxt;
    e.exp_reach = e_reach;
    e.exp_locq  = e_locq;
    e.chk_locq  = chk;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    n_compared++;
    if (nxtLoc !== e.exp_nxt) begin
      n_failed++;
      $display("[TB] FAIL vec%0d nxtLoc: got %h expected %h", e.tag, nxtLoc, e.exp_nxt);
    end
    n_compared++;
    if (cntReach !== e.exp_reach) begin
      n_failed++;
      $display("[TB] FAIL vec%0d cntReach: got %b expected %b", e.tag, cntReach, e.exp_reach);
    end
    if (e.chk_locq) begin
      n_compared++;
      if (locQ !== e.exp_locq) begin
        n_failed++;
        $display("[TB] FAIL vec%0d locQ: got %h expected %h", e.tag, locQ, e.exp_locq);
      end
    end
  endtask

  // Monitor samples on the falling edge, mid-cycle after inputs settled.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

`ifdef LOC_STEP_SAT_EN
  localparam logic [7:0] UP_EDGE  = 8'hF3;
  localparam logic [7:0] LO_EDGE  = 8'h70;
  localparam logic [7:0] LOW_UP   = 8'h0F;
  localparam logic [7:0] HI_DOWN  = 8'h09;
`else
  localparam logic [7:0] UP_EDGE  = 8'h03;
  localparam logic [7:0] LO_EDGE  = 8'h7F;
  localparam logic [7:0] LOW_UP   = 8'h00;
  localparam logic [7:0] HI_DOWN  = 8'hF9;
`endif

  initial begin
    int waited;
    rst = 1'b1; rgLd = 1'b0; dir = 2'b00; curLoc = 8'h00;
    //            tag rst ld  dir    curLoc  nxt      reach locQ   chk
    applyStimulus(0,  1, 1, 2'b00, 8'hA5, 8'hA4,   0, 8'h00, 0);
    applyStimulus(1,  0, 1, 2'b00, 8'hA5, 8'hA4,   0, 8'h00, 1);
    applyStimulus(2,  0, 0, 2'b00, 8'h55, 8'h54,   0, 8'hA5, 1);
    applyStimulus(3,  0, 0, 2'b01, 8'h55, 8'h65,   0, 8'hA5, 1);
    applyStimulus(4,  0, 0, 2'b10, 8'h55, 8'h45,   0, 8'hA5, 1);
    applyStimulus(5,  0, 0, 2'b11, 8'h55, 8'h56,   0, 8'hA5, 1);
    applyStimulus(6,  0, 0, 2'b01, 8'hF3, UP_EDGE, 1, 8'hA5, 1);
    applyStimulus(7,  0, 0, 2'b00, 8'h70, LO_EDGE, 1, 8'hA5, 1);
    applyStimulus(8,  0, 0, 2'b11, 8'h0F, LOW_UP,  1, 8'hA5, 1);
    applyStimulus(9,  0, 0, 2'b10, 8'h09, HI_DOWN, 1, 8'hA5, 1);
    applyStimulus(10, 0, 1, 2'b11, 8'h3C, 8'h3D,   0, 8'hA5, 1);
    applyStimulus(11, 1, 1, 2'b11, 8'h3C, 8'h3D,   0, 8'h3C, 1);
    applyStimulus(12, 0, 0, 2'b01, 8'hB2, 8'hC2,   0, 8'h00, 1);
    applyStimulus(13, 0, 1, 2'b10, 8'hB2, 8'hA2,   0, 8'h00, 1);
    applyStimulus(14, 0, 0, 2'b00, 8'h11, 8'h10,   0, 8'hB2, 1);
    stim_done = 1'b1;

    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end
endmodule
